// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU op codes, ONZC flag indices and arbiter state type
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SLT  = 4'b0101;
   localparam logic [3:0] OP_SLL  = 4'b0110;
   localparam logic [3:0] OP_SLTU = 4'b0111;
   localparam logic [3:0] OP_SRL  = 4'b1000;
   localparam logic [3:0] OP_SRA  = 4'b1001;

   localparam int FLAG_O = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_C = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   // Codes above SRA have no ALU meaning.
   function automatic logic is_illegal_op(input logic [3:0] ctrl);
      return ctrl > OP_SRA;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting at a pointer
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_BITS = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_BITS-1:0] ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_BITS-1:0] gnt_idx,
   output logic               gnt_any
);

   // Scan from ptr upward with wrap; the first set request wins.
   always_comb begin
      int idx;
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!gnt_any && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_idx  = ID_BITS'(idx);
            gnt_any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU; ALU_ILLEGAL_CHK_EN enables illegal-op bypass
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int REG_BITS = 32,
   parameter int NUM_REQ  = 2,
   parameter int ID_BITS  = $clog2(NUM_REQ)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*REG_BITS-1:0]  req_a,
   input  logic [NUM_REQ*REG_BITS-1:0]  req_b,
   input  logic [NUM_REQ*4-1:0]         req_ctrl,
   output logic [NUM_REQ-1:0]           rsp_valid,
   input  logic [NUM_REQ-1:0]           rsp_ready,
   output logic [REG_BITS-1:0]          rsp_c,
   output logic [3:0]                   rsp_onzc,
   output logic                         rsp_err,
   output logic [REG_BITS-1:0]          alu_a,
   output logic [REG_BITS-1:0]          alu_b,
   output logic [3:0]                   alu_ctrl,
   input  logic [REG_BITS-1:0]          alu_c,
   input  logic [3:0]                   alu_onzc
);

   arb_state_e          state_q, state_d;
   logic [ID_BITS-1:0]  ptr_q, ptr_d;
   logic [ID_BITS-1:0]  id_q, id_d;
   logic [REG_BITS-1:0] a_q, a_d;
   logic [REG_BITS-1:0] b_q, b_d;
   logic [3:0]          ctrl_q, ctrl_d;
   logic [REG_BITS-1:0] rsp_c_q, rsp_c_d;
   logic [3:0]          rsp_onzc_q, rsp_onzc_d;
   logic                rsp_err_q, rsp_err_d;

   logic [NUM_REQ-1:0]  gnt;
   logic [ID_BITS-1:0]  gnt_idx;
   logic                gnt_any;
   logic [REG_BITS-1:0] sel_a, sel_b;
   logic [3:0]          sel_ctrl;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_BITS (ID_BITS)
   ) u_rr (
      .req     (req_valid),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   assign sel_a    = req_a[gnt_idx*REG_BITS +: REG_BITS];
   assign sel_b    = req_b[gnt_idx*REG_BITS +: REG_BITS];
   assign sel_ctrl = req_ctrl[gnt_idx*4 +: 4];

   assign req_ready = (state_q == IDLE) ? gnt : '0;
   assign rsp_valid = (state_q == RESP) ? (NUM_REQ'(1) << id_q) : '0;
   assign rsp_c     = rsp_c_q;
   assign rsp_onzc  = rsp_onzc_q;
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_ctrl  = ctrl_q;
`ifdef ALU_ILLEGAL_CHK_EN
   assign rsp_err   = rsp_err_q;
`else
   assign rsp_err   = 1'b0;
`endif

   // Next-state: accept in IDLE, capture ALU result in EXEC, hold response in RESP.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      id_d       = id_q;
      a_d        = a_q;
      b_d        = b_q;
      ctrl_d     = ctrl_q;
      rsp_c_d    = rsp_c_q;
      rsp_onzc_d = rsp_onzc_q;
      rsp_err_d  = rsp_err_q;
      case (state_q)
         IDLE: begin
            if (gnt_any) begin
               id_d = gnt_idx;
               a_d  = sel_a;
               b_d  = sel_b;
`ifdef ALU_ILLEGAL_CHK_EN
               if (is_illegal_op(sel_ctrl)) begin
                  // Illegal ops never reach the ALU; answer immediately.
                  rsp_c_d    = '0;
                  rsp_onzc_d = 4'b0000;
                  rsp_err_d  = 1'b1;
                  state_d    = RESP;
               end else begin
                  ctrl_d    = sel_ctrl;
                  rsp_err_d = 1'b0;
                  state_d   = EXEC;
               end
`else
               ctrl_d    = sel_ctrl;
               rsp_err_d = 1'b0;
               state_d   = EXEC;
`endif
            end
         end
         EXEC: begin
            rsp_c_d    = alu_c;
            rsp_onzc_d = alu_onzc;
            state_d    = RESP;
         end
         RESP: begin
            if (rsp_ready[id_q]) begin
               state_d = IDLE;
               ptr_d   = (id_q == ID_BITS'(NUM_REQ - 1)) ? '0 : id_q + ID_BITS'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         id_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         ctrl_q     <= 4'b0000;
         rsp_c_q    <= '0;
         rsp_onzc_q <= 4'b0000;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         id_q       <= id_d;
         a_q        <= a_d;
         b_q        <= b_d;
         ctrl_q     <= ctrl_d;
         rsp_c_q    <= rsp_c_d;
         rsp_onzc_q <= rsp_onzc_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

endmodule
